// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RSP} arb_state_e;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS} arb_owner_e;

    localparam logic [3:0] BE_ALL = 4'hF;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_arb_pick.sv
// Two-way requester picker: fixed LS>IF priority by default.
// With ARB_ROUND_ROBIN_EN defined, a simultaneous pair goes to the requester that did not win last.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       if_req_i,
    input  logic       ls_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_owner_e rr_last_i,
`endif
    output arb_owner_e owner_o
);

    // Choose the winner among pending requesters
    always_comb begin
        owner_o = OWN_NONE;
        if (ls_req_i && if_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            owner_o = (rr_last_i == OWN_LS) ? OWN_IF : OWN_LS;
`else
            owner_o = OWN_LS;
`endif
        end else if (ls_req_i) begin
            owner_o = OWN_LS;
        end else if (if_req_i) begin
            owner_o = OWN_IF;
        end
    end

endmodule : arb_pick

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store,
// one outstanding transaction, with a response watchdog.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin on simultaneous requests).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DW-1:0]     if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [DW/8-1:0]   ls_be,
    input  logic [AW-1:0]     ls_addr,
    input  logic [DW-1:0]     ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DW-1:0]     ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DW-1:0]     mem_rdata,
    output logic              err
);

    localparam int unsigned BEW = DW / 8;
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
    // IF fetches full words; BE_ALL covers the 32-bit case, wider buses fill with ones
    localparam logic [BEW-1:0] BE_IF = (BEW == 4) ? BEW'(BE_ALL) : {BEW{1'b1}};

    arb_state_e    state_q, state_d;
    arb_owner_e    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    arb_owner_e    pick_c;
    logic          timeout_c;
    logic          rsp_done_c;

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_e    rr_last_q, rr_last_d;
`endif

    arb_pick u_arb_pick (
        .if_req_i  (if_req),
        .ls_req_i  (ls_req),
`ifdef ARB_ROUND_ROBIN_EN
        .rr_last_i (rr_last_q),
`endif
        .owner_o   (pick_c)
    );

    // Watchdog fires on the last allowed RSP cycle with no response
    assign timeout_c  = (state_q == RSP) && !mem_rvalid && (cnt_q == CNT_LAST);
    assign rsp_done_c = (state_q == RSP) && (mem_rvalid || timeout_c);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Owner, watchdog counter and round-robin history registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q <= OWN_IF;
`endif
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

    // Next-state, owner and counter logic
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = '0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_last_d = rr_last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_c != OWN_NONE) begin
                    state_d   = REQ;
                    owner_d   = pick_c;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_last_d = pick_c;
`endif
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                cnt_d = cnt_q + CW'(1);
                if (rsp_done_c) begin
                    cnt_d = '0;
                    if (pick_c != OWN_NONE) begin
                        state_d   = REQ;
                        owner_d   = pick_c;
`ifdef ARB_ROUND_ROBIN_EN
                        rr_last_d = pick_c;
`endif
                    end else begin
                        state_d = IDLE;
                        owner_d = OWN_NONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Output muxes; everything is held at zero while reset is asserted
    always_comb begin
        if_gnt    = 1'b0;
        if_rvalid = 1'b0;
        if_rdata  = '0;
        ls_gnt    = 1'b0;
        ls_rvalid = 1'b0;
        ls_rdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        err       = 1'b0;
        if (rst) begin
            if (state_q == REQ) begin
                mem_req = 1'b1;
                if (owner_q == OWN_LS) begin
                    mem_we    = ls_we;
                    mem_be    = ls_be;
                    mem_addr  = ls_addr;
                    mem_wdata = ls_we ? ls_wdata : '0;
                    ls_gnt    = mem_gnt;
                end else if (owner_q == OWN_IF) begin
                    mem_be   = BE_IF;
                    mem_addr = if_addr;
                    if_gnt   = mem_gnt;
                end
            end
            if (rsp_done_c) begin
                err = timeout_c;
                if (owner_q == OWN_LS) begin
                    ls_rvalid = 1'b1;
                    ls_rdata  = mem_rvalid ? mem_rdata : '0;
                end else if (owner_q == OWN_IF) begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rvalid ? mem_rdata : '0;
                end
            end
        end
    end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req, ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata;
    logic        ls_gnt, ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(4), .AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are then driven
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after driving inputs
    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] any_out();
        return 32'(|{if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata, err});
    endfunction

    initial begin
        logic exp_ls;
        rst = 1'b0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0;
        ls_addr = 0; ls_wdata = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

        // Reset
        cyc(); cyc(); settle();
        chk("reset_all_zero", any_out(), 0);
        rst = 1'b1;

        // T1: IF-only read, grant on 2nd REQ cycle, response on 3rd RSP cycle
        cyc(); if_req = 1; if_addr = 32'h100; settle();
        chk("t1_idle_no_req", 32'(mem_req), 0);
        cyc(); settle();
        chk("t1_req", 32'(mem_req), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", 32'(mem_be), 32'hF);
        chk("t1_we", 32'(mem_we), 0);
        chk("t1_no_gnt_yet", 32'(if_gnt), 0);
        cyc(); mem_gnt = 1; settle();
        chk("t1_if_gnt", 32'(if_gnt), 1);
        chk("t1_ls_gnt", 32'(ls_gnt), 0);
        cyc(); if_req = 0; mem_gnt = 0; settle();
        chk("t1_rsp_no_req", 32'(mem_req), 0);
        chk("t1_rsp_addr0", mem_addr, 0);
        chk("t1_rsp_wait", 32'(if_rvalid), 0);
        cyc(); settle();
        cyc(); mem_rvalid = 1; mem_rdata = 32'hDEADBEEF; settle();
        chk("t1_if_rvalid", 32'(if_rvalid), 1);
        chk("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("t1_ls_rvalid", 32'(ls_rvalid), 0);
        chk("t1_ls_rdata", ls_rdata, 0);
        chk("t1_err", 32'(err), 0);
        cyc(); mem_rvalid = 0; settle();
        chk("t1_rdata_cleared", if_rdata, 0);
        chk("t1_back_idle", 32'(mem_req), 0);

        // T2: simultaneous IF + LS store; LS first, IF back-to-back
        cyc(); if_req = 1; if_addr = 32'h104; ls_req = 1; ls_we = 1;
        ls_addr = 32'h20; ls_wdata = 32'h12345678; ls_be = 4'h3; settle();
        cyc(); mem_gnt = 1; settle();
        chk("t2_ls_gnt", 32'(ls_gnt), 1);
        chk("t2_if_gnt", 32'(if_gnt), 0);
        chk("t2_we", 32'(mem_we), 1);
        chk("t2_be", 32'(mem_be), 32'h3);
        chk("t2_addr", mem_addr, 32'h20);
        chk("t2_wdata", mem_wdata, 32'h12345678);
        cyc(); ls_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 0; settle();
        chk("t2_ls_rvalid", 32'(ls_rvalid), 1);
        chk("t2_if_rvalid", 32'(if_rvalid), 0);
        cyc(); mem_rvalid = 0; settle();
        chk("t2_b2b_req", 32'(mem_req), 1);
        chk("t2_b2b_addr", mem_addr, 32'h104);
        chk("t2_b2b_be", 32'(mem_be), 32'hF);
        chk("t2_b2b_wdata", mem_wdata, 0);
        mem_gnt = 1; settle();
        chk("t2_b2b_if_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE0001; settle();
        chk("t2_if_rdata", if_rdata, 32'hCAFE0001);
        cyc(); mem_rvalid = 0; ls_we = 0; settle();

        // T3: both requesters held for four transactions
        if_req = 1; if_addr = 32'h108; ls_req = 1; ls_addr = 32'h30; ls_be = 4'hF;
        cyc(); settle();
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_ls = (i % 2 == 0);
`else
            exp_ls = 1'b1;
`endif
            mem_gnt = 1; settle();
            chk($sformatf("t3_ls_gnt_%0d", i), 32'(ls_gnt), 32'(exp_ls));
            chk($sformatf("t3_if_gnt_%0d", i), 32'(if_gnt), 32'(!exp_ls));
            cyc(); mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'(i);
            if (i == 3) begin
                if_req = 0; ls_req = 0;
            end
            settle();
            chk($sformatf("t3_ls_rvalid_%0d", i), 32'(ls_rvalid), 32'(exp_ls));
            chk($sformatf("t3_if_rvalid_%0d", i), 32'(if_rvalid), 32'(!exp_ls));
            cyc(); mem_rvalid = 0; settle();
        end
        chk("t3_idle", 32'(mem_req), 0);

        // T4: watchdog, memory never responds
        cyc(); if_req = 1; if_addr = 32'h200; settle();
        cyc(); mem_gnt = 1; settle();
        chk("t4_if_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0; mem_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("t4_no_err_%0d", i), 32'(err), 0);
            chk($sformatf("t4_no_rvalid_%0d", i), 32'(if_rvalid), 0);
            cyc();
        end
        settle();
        chk("t4_err", 32'(err), 1);
        chk("t4_if_rvalid", 32'(if_rvalid), 1);
        chk("t4_if_rdata0", if_rdata, 0);
        chk("t4_ls_rvalid", 32'(ls_rvalid), 0);
        cyc(); settle();
        chk("t4_err_pulse", 32'(err), 0);
        chk("t4_idle_a", 32'(mem_req), 0);
        cyc(); settle();
        chk("t4_idle_b", 32'(mem_req), 0);

        // T5: reset mid-RSP, then a stray rvalid
        cyc(); ls_req = 1; ls_we = 0; ls_addr = 32'h40; settle();
        cyc(); mem_gnt = 1; settle();
        chk("t5_ls_gnt", 32'(ls_gnt), 1);
        cyc(); ls_req = 0; mem_gnt = 0; rst = 0; settle();
        chk("t5_rst_zero_a", any_out(), 0);
        cyc(); settle();
        chk("t5_rst_zero_b", any_out(), 0);
        cyc(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h55; settle();
        chk("t5_stray_ls", 32'(ls_rvalid), 0);
        chk("t5_stray_if", 32'(if_rvalid), 0);
        chk("t5_stray_rdata", ls_rdata, 0);
        cyc(); mem_rvalid = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk($sformatf("t5_idle_%0d", i), any_out(), 0);
            cyc();
        end

        // T6: rvalid during REQ is ignored
        if_req = 1; if_addr = 32'h300; settle();
        cyc(); mem_rvalid = 1; mem_rdata = 32'h77; settle();
        chk("t6_req", 32'(mem_req), 1);
        chk("t6_no_rvalid", 32'(if_rvalid), 0);
        chk("t6_no_rdata", if_rdata, 0);
        cyc(); mem_rvalid = 0; settle();
        chk("t6_still_req", 32'(mem_req), 1);
        chk("t6_addr", mem_addr, 32'h300);
        mem_gnt = 1; settle();
        chk("t6_if_gnt", 32'(if_gnt), 1);
        cyc(); if_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h99; settle();
        chk("t6_if_rdata", if_rdata, 32'h99);
        cyc(); mem_rvalid = 0; settle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_arbiter
